// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing and 4x4-replicated scanout of a 160x120 framebuffer
module vga_scanout #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FRONT     = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter int FB_WIDTH    = 160,
   parameter int SCALE_SHIFT = 2
) (
   input  logic        clk,
   input  logic        resetn,
   output logic [14:0] rd_addr,
   input  logic [2:0]  rd_data,
   output logic        vga_clk,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic        vga_sync_n,
   output logic [9:0]  vga_r,
   output logic [9:0]  vga_g,
   output logic [9:0]  vga_b,
   output logic        frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FRONT);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FRONT);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [14:0] STRIDE = 15'(FB_WIDTH);

   logic        phase;
   logic        pix_en;
   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic        h_wrap;
   logic        v_wrap;
   logic        active0;
   logic        hs0;
   logic        vs0;
   logic [7:0]  px;
   logic [6:0]  py;
   logic [14:0] addr0;
   logic        active1;
   logic        hs1;
   logic        vs1;

   assign pix_en     = phase;
   assign vga_clk    = phase;
   assign vga_sync_n = 1'b0;

   // stage 0: raster decode and framebuffer address (stride 160 reduces to (py<<7)+(py<<5))
   always_comb begin
      h_wrap  = h_cnt == H_LAST;
      v_wrap  = v_cnt == V_LAST;
      active0 = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      hs0     = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
      vs0     = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
      px      = 8'(h_cnt >> SCALE_SHIFT);
      py      = 7'(v_cnt >> SCALE_SHIFT);
      addr0   = active0 ? 15'(15'(py) * STRIDE) + 15'(px) : 15'd0;
   end

   // pixel phase toggles every clk; raster counters advance once per pixel tick
   always_ff @(posedge clk) begin
      if (!resetn) begin
         phase <= 1'b0;
         h_cnt <= 10'd0;
         v_cnt <= 10'd0;
      end else begin
         phase <= ~phase;
         if (pix_en) begin
            h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
            if (h_wrap)
               v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
         end
      end
   end

   // one-clk tick on the pixel tick where the raster returns to the top-left corner
   always_ff @(posedge clk) begin
      if (!resetn)
         frame_start <= 1'b0;
      else
         frame_start <= pix_en && h_wrap && v_wrap;
   end

   // stage 1: issue the read address and carry the timing flags alongside it
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_addr <= 15'd0;
         active1 <= 1'b0;
         hs1     <= 1'b1;
         vs1     <= 1'b1;
      end else if (pix_en) begin
         rd_addr <= addr0;
         active1 <= active0;
         hs1     <= hs0;
         vs1     <= vs0;
      end
   end

   // stage 2: drive the DAC with colour forced to black outside the active area
   always_ff @(posedge clk) begin
      if (!resetn) begin
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
         vga_r       <= 10'd0;
         vga_g       <= 10'd0;
         vga_b       <= 10'd0;
      end else if (pix_en) begin
         vga_hs      <= hs1;
         vga_vs      <= vs1;
         vga_blank_n <= active1;
         vga_r       <= active1 ? {10{rd_data[2]}} : 10'd0;
         vga_g       <= active1 ? {10{rd_data[1]}} : 10'd0;
         vga_b       <= active1 ? {10{rd_data[0]}} : 10'd0;
      end
   end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed checks of scanout timing, addressing, colour pipeline and reset
module tb_vga_scanout;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        stuck = 1'b0;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   logic [14:0] rd_addr, rd_addr_s;
   logic [2:0]  rd_data, rd_data_s;
   logic        vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;
   logic [9:0]  vga_r, vga_g, vga_b;
   logic        vga_clk_s, vga_hs_s, vga_vs_s, vga_blank_n_s, vga_sync_n_s, frame_start_s;
   logic [9:0]  vga_r_s, vga_g_s, vga_b_s;

   vga_scanout dut (
      .clk(clk), .resetn(resetn), .rd_addr(rd_addr), .rd_data(rd_data),
      .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
      .vga_sync_n(vga_sync_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .frame_start(frame_start)
   );

   // short-frame instance: 16 lines per frame so vertical timing fits the cycle budget
   vga_scanout #(.V_ACTIVE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(4)) dut_s (
      .clk(clk), .resetn(resetn), .rd_addr(rd_addr_s), .rd_data(rd_data_s),
      .vga_clk(vga_clk_s), .vga_hs(vga_hs_s), .vga_vs(vga_vs_s), .vga_blank_n(vga_blank_n_s),
      .vga_sync_n(vga_sync_n_s), .vga_r(vga_r_s), .vga_g(vga_g_s), .vga_b(vga_b_s),
      .frame_start(frame_start_s)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= resetn ? cyc + 1 : 0;

   always @(posedge clk) begin
      rd_data   <= stuck ? 3'b111 : rd_addr[2:0];
      rd_data_s <= rd_addr_s[2:0];
   end

   task automatic goto(input int e);
      while (cyc < e) @(negedge clk);
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      total++; if (rd_addr !== 15'd0) begin bad++; $display("FAIL reset_rd_addr got=%0d want=0", rd_addr); end
      total++; if (vga_hs !== 1'b1) begin bad++; $display("FAIL reset_hs got=%b want=1", vga_hs); end
      total++; if (vga_vs !== 1'b1) begin bad++; $display("FAIL reset_vs got=%b want=1", vga_vs); end
      total++; if (vga_blank_n !== 1'b0) begin bad++; $display("FAIL reset_blank_n got=%b want=0", vga_blank_n); end
      total++; if ({vga_r, vga_g, vga_b} !== 30'd0) begin bad++; $display("FAIL reset_rgb got=%h want=0", {vga_r, vga_g, vga_b}); end
      total++; if (vga_clk !== 1'b0 || frame_start !== 1'b0) begin bad++; $display("FAIL reset_clk_fs got=%b%b want=00", vga_clk, frame_start); end
      total++; if (vga_sync_n !== 1'b0) begin bad++; $display("FAIL sync_n got=%b want=0", vga_sync_n); end
      resetn = 1'b1;
      goto(1);
      total++; if (vga_clk !== 1'b1) begin bad++; $display("FAIL vga_clk_hi got=%b want=1", vga_clk); end
      goto(2);
      total++; if (vga_clk !== 1'b0) begin bad++; $display("FAIL vga_clk_lo got=%b want=0", vga_clk); end
   endtask

   task automatic test_addressing_colour;
      goto(3);
      total++; if (vga_blank_n !== 1'b0) begin bad++; $display("FAIL blank_pre got=%b want=0", vga_blank_n); end
      goto(4);
      total++; if (vga_blank_n !== 1'b1) begin bad++; $display("FAIL blank_first got=%b want=1", vga_blank_n); end
      goto(10);
      total++; if (rd_addr !== 15'd1) begin bad++; $display("FAIL addr_h4 got=%0d want=1", rd_addr); end
      goto(14);
      total++; if ({vga_r, vga_g, vga_b} !== {10'h000, 10'h000, 10'h3ff}) begin bad++; $display("FAIL colour_h5 got=%h want=%h", {vga_r, vga_g, vga_b}, {10'h000, 10'h000, 10'h3ff}); end
      goto(16);
      total++; if (rd_addr !== 15'd1) begin bad++; $display("FAIL addr_h7 got=%0d want=1", rd_addr); end
      goto(18);
      total++; if (rd_addr !== 15'd2) begin bad++; $display("FAIL addr_h8 got=%0d want=2", rd_addr); end
      goto(20);
      total++; if ({vga_r, vga_g, vga_b} !== {10'h000, 10'h3ff, 10'h000} || vga_blank_n !== 1'b1) begin bad++; $display("FAIL colour_h8 got=%h/%b want=%h/1", {vga_r, vga_g, vga_b}, vga_blank_n, {10'h000, 10'h3ff, 10'h000}); end
      goto(1280);
      total++; if (rd_addr !== 15'd159) begin bad++; $display("FAIL addr_h639 got=%0d want=159", rd_addr); end
      goto(1282);
      total++; if (rd_addr !== 15'd0) begin bad++; $display("FAIL addr_h640 got=%0d want=0", rd_addr); end
   endtask

   task automatic test_blank_forcing;
      stuck = 1'b1;
      goto(1300);
      total++; if (vga_blank_n !== 1'b0 || {vga_r, vga_g, vga_b} !== 30'd0) begin bad++; $display("FAIL blank_force got=%b/%h want=0/0", vga_blank_n, {vga_r, vga_g, vga_b}); end
   endtask

   task automatic test_first_hs;
      goto(1315);
      total++; if (vga_hs !== 1'b1) begin bad++; $display("FAIL hs_before got=%b want=1", vga_hs); end
      goto(1316);
      total++; if (vga_hs !== 1'b0 || {vga_r, vga_g, vga_b} !== 30'd0) begin bad++; $display("FAIL hs_first got=%b/%h want=0/0", vga_hs, {vga_r, vga_g, vga_b}); end
   endtask

   task automatic test_h_timing;
      int t0, t1, n;
      t0 = cyc; n = 0;
      while (vga_hs === 1'b0 && n < 2000) begin @(negedge clk); n++; end
      total++; if (cyc - t0 !== 192) begin bad++; $display("FAIL hs_width got=%0d want=192", cyc - t0); end
      n = 0;
      while (vga_hs === 1'b1 && n < 3000) begin @(negedge clk); n++; end
      total++; if (cyc - t0 !== 1600) begin bad++; $display("FAIL hs_period got=%0d want=1600", cyc - t0); end
      n = 0;
      while (vga_blank_n === 1'b0 && n < 3000) begin @(negedge clk); n++; end
      t1 = cyc;
      total++; if (t1 !== 3204) begin bad++; $display("FAIL blank_rise got=%0d want=3204", t1); end
      total++; if ({vga_r, vga_g, vga_b} !== {30{1'b1}}) begin bad++; $display("FAIL active_white got=%h want=%h", {vga_r, vga_g, vga_b}, {30{1'b1}}); end
      n = 0;
      while (vga_blank_n === 1'b1 && n < 3000) begin @(negedge clk); n++; end
      total++; if (cyc - t1 !== 1280) begin bad++; $display("FAIL blank_width got=%0d want=1280", cyc - t1); end
   endtask

   task automatic test_v4_addressing;
      goto(6402);
      total++; if (rd_addr !== 15'd160) begin bad++; $display("FAIL addr_v4 got=%0d want=160", rd_addr); end
      goto(6410);
      total++; if (rd_addr !== 15'd161) begin bad++; $display("FAIL addr_v4h4 got=%0d want=161", rd_addr); end
   endtask

   task automatic test_short_frame;
      int t0, n;
      goto(12480);
      total++; if (rd_addr_s !== 15'd319) begin bad++; $display("FAIL s_addr_last got=%0d want=319", rd_addr_s); end
      goto(12802);
      total++; if (rd_addr_s !== 15'd0) begin bad++; $display("FAIL s_addr_vblank got=%0d want=0", rd_addr_s); end
      goto(16003);
      total++; if (vga_vs_s !== 1'b1) begin bad++; $display("FAIL s_vs_before got=%b want=1", vga_vs_s); end
      goto(16004);
      total++; if (vga_vs_s !== 1'b0) begin bad++; $display("FAIL s_vs_fall got=%b want=0", vga_vs_s); end
      t0 = cyc; n = 0;
      while (vga_vs_s === 1'b0 && n < 5000) begin @(negedge clk); n++; end
      total++; if (cyc - t0 !== 3200) begin bad++; $display("FAIL s_vs_width got=%0d want=3200", cyc - t0); end
      goto(25599);
      total++; if (frame_start_s !== 1'b0) begin bad++; $display("FAIL s_fs_early got=%b want=0", frame_start_s); end
      goto(25600);
      total++; if (frame_start_s !== 1'b1 || frame_start !== 1'b0) begin bad++; $display("FAIL s_fs_pulse got=%b/%b want=1/0", frame_start_s, frame_start); end
      goto(25601);
      total++; if (frame_start_s !== 1'b0) begin bad++; $display("FAIL s_fs_width got=%b want=0", frame_start_s); end
      goto(25602);
      total++; if (rd_addr_s !== 15'd0) begin bad++; $display("FAIL s_wrap_addr0 got=%0d want=0", rd_addr_s); end
      goto(25604);
      total++; if (vga_blank_n_s !== 1'b1) begin bad++; $display("FAIL s_wrap_blank got=%b want=1", vga_blank_n_s); end
      goto(25610);
      total++; if (rd_addr_s !== 15'd1) begin bad++; $display("FAIL s_wrap_addr1 got=%0d want=1", rd_addr_s); end
      n = 0;
      while (vga_vs_s === 1'b1 && n < 30000) begin @(negedge clk); n++; end
      total++; if (cyc - t0 !== 25600) begin bad++; $display("FAIL s_vs_period got=%0d want=25600", cyc - t0); end
      n = 0;
      while (frame_start_s !== 1'b1 && n < 30000) begin @(negedge clk); n++; end
      total++; if (cyc !== 51200) begin bad++; $display("FAIL s_fs_period got=%0d want=51200", cyc); end
   endtask

   task automatic test_mid_frame_reset;
      goto(52000);
      total++; if (vga_blank_n !== 1'b1 || vga_vs !== 1'b1) begin bad++; $display("FAIL mid_active got=%b%b want=11", vga_blank_n, vga_vs); end
      resetn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      total++; if (rd_addr !== 15'd0 || vga_hs !== 1'b1 || vga_vs !== 1'b1 || vga_blank_n !== 1'b0) begin bad++; $display("FAIL mid_reset_ctl got=%0d/%b%b%b want=0/110", rd_addr, vga_hs, vga_vs, vga_blank_n); end
      total++; if ({vga_r, vga_g, vga_b} !== 30'd0 || vga_clk !== 1'b0 || frame_start !== 1'b0) begin bad++; $display("FAIL mid_reset_out got=%h/%b%b want=0/00", {vga_r, vga_g, vga_b}, vga_clk, frame_start); end
      resetn = 1'b1;
      goto(3);
      total++; if (vga_blank_n !== 1'b0) begin bad++; $display("FAIL mid_restart_pre got=%b want=0", vga_blank_n); end
      goto(4);
      total++; if (vga_blank_n !== 1'b1) begin bad++; $display("FAIL mid_restart_blank got=%b want=1", vga_blank_n); end
      goto(10);
      total++; if (rd_addr !== 15'd1) begin bad++; $display("FAIL mid_restart_addr got=%0d want=1", rd_addr); end
      goto(1316);
      total++; if (vga_hs !== 1'b0) begin bad++; $display("FAIL mid_restart_hs got=%b want=0", vga_hs); end
   endtask

   initial begin
      test_reset;
      test_addressing_colour;
      test_blank_forcing;
      test_first_hs;
      test_h_timing;
      test_v4_addressing;
      test_short_frame;
      test_mid_frame_reset;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Reader end of the 160x120 pixel framebuffer. The game-side display logic writes pixels (x, y, 3-bit colour) into that buffer; this block reads them back out.
- Generates 640x480@60 Hz VGA timing from the 50 MHz system clock and reads the buffer through a synchronous-read port.
- Replicates each stored pixel 4x4 and drives sync, blank and colour to the DAC.
- Also emits a once-per-frame pulse that game logic can use as a tick.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, h front porch in pixel ticks
- H_SYNC, 96, h sync width in pixel ticks
- H_BACK, 48, h back porch in pixel ticks
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, v front porch in lines
- V_SYNC, 2, v sync width in lines
- V_BACK, 33, v back porch in lines
- FB_WIDTH, 160, framebuffer pixels per row (address stride)
- SCALE_SHIFT, 2, log2 of the replication factor (640>>2=160, 480>>2=120)

Ports:
- clk  in  1  50 MHz system clock
- resetn  in  1  reset (see Behaviour)
- rd_addr  out  15  framebuffer read address = py*FB_WIDTH + px
- rd_data  in  3  framebuffer data; valid one clk after rd_addr changes; [2]=R, [1]=G, [0]=B
- vga_clk  out  1  25 MHz pixel clock to the DAC
- vga_hs  out  1  horizontal sync, active low
- vga_vs  out  1  vertical sync, active low
- vga_blank_n  out  1  low outside the active area
- vga_sync_n  out  1  constant 0 (sync-on-green unused)
- vga_r, vga_g, vga_b  out  10 each  colour bit replicated across all 10 bits
- frame_start  out  1  one-clk pulse at the start of each frame

Behaviour:
- Reset: resetn is synchronous, active-low; clock clk. While resetn=0, all state clears on the next clk edge: h_cnt=0, v_cnt=0, pixel phase=0, vga_clk=0, rd_addr=0, vga_hs=1, vga_vs=1, vga_blank_n=0, vga_r/g/b=0, frame_start=0, pipeline registers cleared. This applies equally to reset asserted mid-frame. After release, counting restarts at h=0, v=0.
- Pixel tick: a phase bit toggles every clk. pix_en = (phase==1), so pix_en is high on every second clk. vga_clk = phase register, so its rising edge falls mid-pixel relative to output changes. All pipeline stages advance only on pix_en.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 (H_TOTAL = sum of the H_* parameters = 800), then wraps to 0.
  - v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1 (525), then wraps to 0.
  - Both counters are 10 bits.
- Stage 0 decode from the counters:
  - active = h_cnt<H_ACTIVE and v_cnt<V_ACTIVE
  - hs0 = low when H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC (656..751)
  - vs0 = low when V_ACTIVE+V_FRONT <= v_cnt < V_ACTIVE+V_FRONT+V_SYNC (490..491)
- Stage 1 (registered on pix_en):
  - px = h_cnt>>SCALE_SHIFT (8 bits), py = v_cnt>>SCALE_SHIFT (7 bits)
  - rd_addr = py*160+px computed as (py<<7)+(py<<5)+px, 15 bits, range 0..19199
  - rd_addr = 0 when not active
  - active, hs0 and vs0 are delayed one stage alongside rd_addr
- Memory: rd_data is stable at the pix_en following the rd_addr update. The memory has one clk of latency and there are two clks per tick, so there is margin.
- Stage 2 (registered on pix_en):
  - vga_r = {10{rd_data[2]}}, vga_g = {10{rd_data[1]}}, vga_b = {10{rd_data[0]}} when the delayed active flag is 1, otherwise all 0 regardless of rd_data
  - vga_blank_n = delayed active; vga_hs and vga_vs = delayed hs0/vs0
- Latency: counter value (h,v) at tick k yields rd_addr at tick k+1 and DAC outputs at tick k+2. Colour, sync and blank for the same (h,v) are always co-aligned; there is no skew between them.
- frame_start: high for exactly one clk, on the pix_en clk where the counters transition to h=0, v=0. Not asserted by reset itself.
- Wrap-around: the line after v=524 is v=0 with no gap. rd_addr resets to 0 at the top-left pixel of every frame.

Test Plan:
- Reset: hold resetn=0 for 5 clk -> rd_addr=0, vga_hs=1, vga_vs=1, vga_blank_n=0, rgb=0. Release -> first vga_hs low 2*(656+2)=1316 clk after release (±1 for the phase bit).
- H timing: measure over a line -> vga_hs low for 192 clk, period 1600 clk, vga_blank_n high for 1280 clk per active line.
- V timing: measure -> vga_vs low for 3200 clk, period 840000 clk, frame_start pulse period 840000 clk and 1 clk wide.
- Addressing: h=4..7,v=0 -> rd_addr=1; h=0,v=4 -> 160; h=639,v=479 -> 19199; h=640 (blank) -> 0.
- Colour pipeline: memory model returns addr[2:0]. For pixel (h=8,v=0), rd_addr=2 -> two ticks later vga_r=0, vga_g=3FF, vga_b=0, with vga_blank_n=1 in the same tick.
- Blank forcing and mid-frame reset: rd_data stuck at 3'b111 -> rgb=0 whenever vga_blank_n=0. Assert resetn=0 at v=200 -> outputs return to reset values and counting restarts at h=0, v=0.
